// File: rtl/sap_controller_sequencer_if.sv
// sap_controller_sequencer_if
//   Bundles the SAP-1 controller's opcode input and all of its control strobes.
//   master : the controller (drives strobes and t_state, reads instr)
//   slave  : the datapath side (drives instr, reads strobes and t_state)
//   Signals: instr (IR[7:4]), pc_inc/pc_en/mar_ld/mem_en/ir_ld/ir_en, ldA/enA,
//            ldB, enALU/sub, out_ld, hlt, t_state (one-hot T1..T6).
interface sap_controller_sequencer_if;
    logic [3:0] instr;
    logic       pc_inc;
    logic       pc_en;
    logic       mar_ld;
    logic       mem_en;
    logic       ir_ld;
    logic       ir_en;
    logic       ldA;
    logic       enA;
    logic       ldB;
    logic       enALU;
    logic       sub;
    logic       out_ld;
    logic       hlt;
    logic [5:0] t_state;

    modport master (
        input  instr,
        output pc_inc, pc_en, mar_ld, mem_en, ir_ld, ir_en,
        output ldA, enA, ldB, enALU, sub, out_ld, hlt, t_state
    );

    modport slave (
        output instr,
        input  pc_inc, pc_en, mar_ld, mem_en, ir_ld, ir_en,
        input  ldA, enA, ldB, enALU, sub, out_ld, hlt, t_state
    );
endinterface

// File: rtl/sap_controller_sequencer.sv
// sap_controller_sequencer
//   SAP-1 controller-sequencer: six-state one-hot fetch/execute ring plus opcode
//   decode driving every control strobe of the shared 8-bit bus.
//   clk : rising-edge system clock
//   clr : synchronous active-low reset; also forces all controls low while 0
//   bus : master side of sap_controller_sequencer_if (instr in, strobes and
//         t_state out)
//   Only the ring and the halted flag are registered; all strobes are decoded
//   combinationally from the current ring state and instr.
module sap_controller_sequencer #(
    parameter int unsigned T_STATES = 6
) (
    input  logic                              clk,
    input  logic                              clr,
    sap_controller_sequencer_if.master        bus
);

    typedef enum logic [T_STATES-1:0] {
        StT1 = 6'b000001,
        StT2 = 6'b000010,
        StT3 = 6'b000100,
        StT4 = 6'b001000,
        StT5 = 6'b010000,
        StT6 = 6'b100000
    } ringE;

    localparam logic [3:0] OpLda = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpOut = 4'b1110;
    localparam logic [3:0] OpHlt = 4'b1111;

    ringE ringQ;
    logic haltedQ;

    // Ring and halted flag. A halted machine parks at T4 until clr.
    always_ff @(posedge clk) begin
        if (!clr) begin
            ringQ   <= StT1;
            haltedQ <= 1'b0;
        end else if (haltedQ) begin
            ringQ   <= StT4;
        end else begin
            case (ringQ)
                StT1: ringQ <= StT2;
                StT2: ringQ <= StT3;
                StT3: ringQ <= StT4;
                StT4: begin
                    if (bus.instr == OpHlt) begin
                        haltedQ <= 1'b1;
                    end else begin
                        ringQ <= StT5;
                    end
                end
                StT5: ringQ <= StT6;
                StT6: ringQ <= StT1;
                // Any illegal encoding reloads T1.
                default: ringQ <= StT1;
            endcase
        end
    end

    assign bus.t_state = ringQ;

    always_comb begin
        bus.pc_inc = 1'b0;
        bus.pc_en  = 1'b0;
        bus.mar_ld = 1'b0;
        bus.mem_en = 1'b0;
        bus.ir_ld  = 1'b0;
        bus.ir_en  = 1'b0;
        bus.ldA    = 1'b0;
        bus.enA    = 1'b0;
        bus.ldB    = 1'b0;
        bus.enALU  = 1'b0;
        bus.sub    = 1'b0;
        bus.out_ld = 1'b0;
        bus.hlt    = 1'b0;
        if (!clr) begin
            // Reset dominates: every strobe, hlt included, stays low.
        end else if (haltedQ) begin
            bus.hlt = 1'b1;
        end else begin
            case (ringQ)
                StT1: begin
                    bus.pc_en  = 1'b1;
                    bus.mar_ld = 1'b1;
                end
                StT2: bus.pc_inc = 1'b1;
                StT3: begin
                    bus.mem_en = 1'b1;
                    bus.ir_ld  = 1'b1;
                end
                StT4: begin
                    case (bus.instr)
                        OpLda, OpAdd, OpSub: begin
                            bus.ir_en  = 1'b1;
                            bus.mar_ld = 1'b1;
                        end
                        OpOut: begin
                            bus.enA    = 1'b1;
                            bus.out_ld = 1'b1;
                        end
                        OpHlt:   bus.hlt = 1'b1;
                        default: ;
                    endcase
                end
                StT5: begin
                    case (bus.instr)
                        OpLda: begin
                            bus.mem_en = 1'b1;
                            bus.ldA    = 1'b1;
                        end
                        OpAdd, OpSub: begin
                            bus.mem_en = 1'b1;
                            bus.ldB    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StT6: begin
                    if (bus.instr == OpAdd || bus.instr == OpSub) begin
                        bus.enALU = 1'b1;
                        bus.ldA   = 1'b1;
                        bus.sub   = (bus.instr == OpSub);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_controller_sequencer.sv
module tb_sap_controller_sequencer;

    logic clk = 1'b0;
    logic clr;

    sap_controller_sequencer_if busIf();

    sap_controller_sequencer #(
        .T_STATES(6)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(busIf)
    );

    always #5 clk = ~clk;

    // Control vector bit positions.
    localparam logic [12:0] PI   = 13'h0001;
    localparam logic [12:0] PE   = 13'h0002;
    localparam logic [12:0] MLD  = 13'h0004;
    localparam logic [12:0] ME   = 13'h0008;
    localparam logic [12:0] IRL  = 13'h0010;
    localparam logic [12:0] IRE  = 13'h0020;
    localparam logic [12:0] LA   = 13'h0040;
    localparam logic [12:0] EA   = 13'h0080;
    localparam logic [12:0] LB   = 13'h0100;
    localparam logic [12:0] EALU = 13'h0200;
    localparam logic [12:0] SB   = 13'h0400;
    localparam logic [12:0] OLD  = 13'h0800;
    localparam logic [12:0] HL   = 13'h1000;
    localparam logic [12:0] NONE = 13'h0000;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef struct packed {
        logic       clr;
        logic [3:0] instr;
        logic [5:0] t;
        logic [12:0] c;
    } vecT;

    typedef struct packed {
        logic [5:0]  t;
        logic [12:0] c;
    } expT;

    vecT vecs[$];
    expT sbQ[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  busDrv;

    function automatic logic [12:0] ctlNow();
        return {busIf.hlt, busIf.out_ld, busIf.sub, busIf.enALU, busIf.ldB, busIf.enA,
                busIf.ldA, busIf.ir_en, busIf.ir_ld, busIf.mem_en, busIf.mar_ld,
                busIf.pc_en, busIf.pc_inc};
    endfunction

    task automatic addVec(input logic c, input logic [3:0] i, input logic [5:0] t,
                          input logic [12:0] e);
        vecT v;
        v.clr   = c;
        v.instr = i;
        v.t     = t;
        v.c     = e;
        vecs.push_back(v);
    endtask

    // Full six-cycle instruction; fetch uses fetchOp to show T1-T3 ignore instr.
    task automatic addInstr(input logic [3:0] fetchOp, input logic [3:0] op,
                            input logic [12:0] c4, input logic [12:0] c5,
                            input logic [12:0] c6);
        addVec(1'b1, fetchOp, T1, PE | MLD);
        addVec(1'b1, fetchOp, T2, PI);
        addVec(1'b1, fetchOp, T3, ME | IRL);
        addVec(1'b1, op, T4, c4);
        addVec(1'b1, op, T5, c5);
        addVec(1'b1, op, T6, c6);
    endtask

    // At most one bus driver in every cycle.
    always @(negedge clk) begin
        busDrv = $countones({busIf.pc_en, busIf.mem_en, busIf.ir_en, busIf.enA,
                             busIf.enALU});
        vectors++;
        if (busDrv > 1) begin
            miscompares++;
            $display("FAIL bus_exclusive t=%0t drivers=%0d required<=1", $time, busDrv);
        end
    end

    initial begin
        expT got;
        expT exp;
        int  hltCyc;

        clr = 1'b0;
        busIf.instr = 4'b0001;

        // Reset held for three clocks.
        for (int k = 0; k < 3; k++) addVec(1'b0, 4'b0001, T1, NONE);
        // LDA with junk opcode during fetch.
        addInstr(4'b1111, 4'b0000, IRE | MLD, ME | LA, NONE);
        addInstr(4'b0001, 4'b0001, IRE | MLD, ME | LB, EALU | LA);
        addInstr(4'b0010, 4'b0010, IRE | MLD, ME | LB, EALU | LA | SB);
        addInstr(4'b1110, 4'b1110, EA | OLD, NONE, NONE);
        addInstr(4'b0101, 4'b0101, NONE, NONE, NONE);
        addInstr(4'b1000, 4'b1000, NONE, NONE, NONE);
        // HLT: stops at T4 and stays there whatever instr does.
        addVec(1'b1, 4'b1111, T1, PE | MLD);
        addVec(1'b1, 4'b1111, T2, PI);
        addVec(1'b1, 4'b1111, T3, ME | IRL);
        addVec(1'b1, 4'b1111, T4, HL);
        for (int k = 0; k < 20; k++) addVec(1'b1, 4'(k), T4, HL);
        addVec(1'b0, 4'b0001, T4, NONE);
        // ADD aborted by reset in T5.
        addVec(1'b1, 4'b0001, T1, PE | MLD);
        addVec(1'b1, 4'b0001, T2, PI);
        addVec(1'b1, 4'b0001, T3, ME | IRL);
        addVec(1'b1, 4'b0001, T4, IRE | MLD);
        addVec(1'b0, 4'b0001, T5, NONE);
        addVec(1'b1, 4'b0001, T1, PE | MLD);
        addVec(1'b1, 4'b0001, T2, PI);
        addVec(1'b1, 4'b0001, T3, ME | IRL);
        addVec(1'b1, 4'b0000, T4, IRE | MLD);

        foreach (vecs[k]) begin
            clr = vecs[k].clr;
            busIf.instr = vecs[k].instr;
            exp.t = vecs[k].t;
            exp.c = vecs[k].c;
            sbQ.push_back(exp);
            @(negedge clk);
            got.t = busIf.t_state;
            got.c = ctlNow();
            exp = sbQ.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL vec%0d t_state=%b ctl=%h required t_state=%b ctl=%h",
                         k, got.t, got.c, exp.t, exp.c);
            end
            @(posedge clk);
            #1;
        end

        // HLT latency from a clean reset: hlt must appear in cycle 4.
        clr = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        busIf.instr = 4'b1111;
        hltCyc = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (busIf.hlt) begin
                hltCyc = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (hltCyc != 4) begin
            miscompares++;
            $display("FAIL hlt_latency cycle=%0d required=4", hltCyc);
        end

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
